alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu.sv | 52 +++++
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice: FSM state encoding and ALU op codes.
package alu_arb_pkg;

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU select encodings (the s input of alu)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // Operand width of the shared alu
    localparam int ALU_W = 4;

endpackage

// File: rtl/alu.sv
// 4-bit combinational ALU.
// f1 = zero, f2 = signed overflow, f3 = carry out; flags are only produced by
// add and subtract, every other op returns all flags clear.
module alu
    import alu_arb_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] s,
    output logic [3:0] z,
    output logic       f1,
    output logic       f2,
    output logic       f3
);

    logic [4:0] sum_add;
    logic [4:0] sum_sub;

    // Subtraction is x + ~y + 1, so f3 is a "no borrow" carry.
    assign sum_add = {1'b0, x} + {1'b0, y};
    assign sum_sub = {1'b0, x} + {1'b0, ~y} + 5'd1;

    // Result and flag selection by op
    always_comb begin
        z  = 4'd0;
        f1 = 1'b0;
        f2 = 1'b0;
        f3 = 1'b0;
        case (s)
            OP_ADD: begin
                z  = sum_add[3:0];
                f3 = sum_add[4];
                f2 = (x[3] == y[3]) && (sum_add[3] != x[3]);
                f1 = (sum_add[3:0] == 4'd0);
            end
            OP_SUB: begin
                z  = sum_sub[3:0];
                f3 = sum_sub[4];
                f2 = (x[3] != y[3]) && (sum_sub[3] != x[3]);
                f1 = (sum_sub[3:0] == 4'd0);
            end
            OP_NOT:  z = ~x;
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_SLT:  z = {3'b000, ($signed(x) < $signed(y))};
            OP_EQ:   z = {3'b000, (x == y)};
            default: z = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu between two requesters.
// Each op takes IDLE -> EXEC -> RESP; the response is held until rsp_ready.
// Optional per-requester saturating grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_z,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic              rsp_carry,
    output logic              busy,
    output logic [STAT_W-1:0] stat0_cnt,
    output logic [STAT_W-1:0] stat1_cnt
);

    // The datapath is hard-wired to the 4-bit alu.
    generate
        if (DATA_W != ALU_W) begin : g_bad_data_w
            $error("alu_arbiter: DATA_W must be 4 to match alu");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic              last_reg;
    logic              grant_any;
    logic              grant_id;
    logic              accept;

    logic [2:0]        op_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic              id_reg;

    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [DATA_W-1:0] rsp_z_reg;
    logic              rsp_zero_reg;
    logic              rsp_ovf_reg;
    logic              rsp_carry_reg;

    logic [3:0]        alu_z;
    logic              alu_f1;
    logic              alu_f2;
    logic              alu_f3;

    // Combinational grant: single requester wins outright, a tie goes to
    // whoever was not served last.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_reg;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state_reg == ST_IDLE) && grant_any;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_EXEC;
            ST_EXEC:                state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept; later request-port changes cannot reach the alu.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
            op_reg   <= 3'd0;
            x_reg    <= '0;
            y_reg    <= '0;
            id_reg   <= 1'b0;
        end else if (accept) begin
            last_reg <= grant_id;
            id_reg   <= grant_id;
            op_reg   <= grant_id ? req1_op : req0_op;
            x_reg    <= grant_id ? req1_x  : req0_x;
            y_reg    <= grant_id ? req1_y  : req0_y;
        end
    end

    alu u_alu (
        .x  (x_reg),
        .y  (y_reg),
        .s  (op_reg),
        .z  (alu_z),
        .f1 (alu_f1),
        .f2 (alu_f2),
        .f3 (alu_f3)
    );

    // Response registers: loaded at the end of EXEC, valid dropped on consume;
    // data and flags keep their last values after the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_z_reg     <= '0;
            rsp_zero_reg  <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
            rsp_carry_reg <= 1'b0;
        end else if (state_reg == ST_EXEC) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_z_reg     <= alu_z;
            rsp_zero_reg  <= alu_f1;
            rsp_ovf_reg   <= alu_f2;
            rsp_carry_reg <= alu_f3;
        end else if (state_reg == ST_RESP && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_z     = rsp_z_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign rsp_carry = rsp_carry_reg;
    assign busy      = (state_reg != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [STAT_W-1:0] cnt_reg;

            // Saturating count of grants to requester gi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (accept && (grant_id == 1'(gi)) && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign stat0_cnt = g_stat[0].cnt_reg;
    assign stat1_cnt = g_stat[1].cnt_reg;
`else
    assign stat0_cnt = '0;
    assign stat1_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (STAT_W=2; counter expectations follow ALU_ARB_STATS_EN).
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DATA_W = 4;
    localparam int STAT_W = 2;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_x, req0_y;
    logic              req1_valid, req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_x, req1_y;
    logic              rsp_valid, rsp_ready, rsp_id;
    logic [DATA_W-1:0] rsp_z;
    logic              rsp_zero, rsp_ovf, rsp_carry, busy;
    logic [STAT_W-1:0] stat0_cnt, stat1_cnt;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_carry  (rsp_carry),
        .busy       (busy),
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one op, let it be accepted, scramble the request ports, then wait
    // (bounded) for rsp_valid. Returns one step after the edge that raised it.
    task automatic send_op(input logic id, input logic [2:0] op,
                           input logic [3:0] x, input logic [3:0] y, output bit got);
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y;
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = ~x; req1_x = ~x; req0_y = ~y; req1_y = ~y; req0_op = ~op; req1_op = ~op;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry} !== 8'd0) begin errors++;
            $display("FAIL reset_rsp_fields got %b exp 0", {rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry}); end
        checks++; if ({stat0_cnt, stat1_cnt} !== 4'd0) begin errors++; $display("FAIL reset_stats got %h exp 0", {stat0_cnt, stat1_cnt}); end
        $display("test_reset done");
    endtask

    // req0 add 7+1 with exact latency checks
    task automatic test_add_latency();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 4'd7; req0_y = 4'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();  // accept edge
        req0_valid = 1'b0; req0_x = 4'd0; req0_y = 4'd0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_exec got valid=%b busy=%b exp valid=0 busy=1", rsp_valid, busy); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency rsp_valid got %b exp 1", rsp_valid); end
        checks++; if ({rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry} !== {1'b0, 4'd8, 1'b0, 1'b1, 1'b0}) begin errors++;
            $display("FAIL add_result got id=%b z=%h zero=%b ovf=%b carry=%b exp id=0 z=8 zero=0 ovf=1 carry=0",
                     rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_z !== 4'd8) begin errors++;
            $display("FAIL add_return got valid=%b busy=%b z=%h exp valid=0 busy=0 z=8", rsp_valid, busy, rsp_z); end
        $display("test_add_latency done: z=%h", rsp_z);
    endtask

    // req1 sub 3-3
    task automatic test_sub();
        bit got;
        rsp_ready = 1'b1;
        send_op(1'b1, OP_SUB, 4'd3, 4'd3, got);
        checks++; if (!got) begin errors++; $display("FAIL sub_timeout got no rsp exp rsp_valid"); end
        checks++; if ({rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry} !== {1'b1, 4'd0, 1'b1, 1'b0, 1'b1}) begin errors++;
            $display("FAIL sub_result got id=%b z=%h zero=%b ovf=%b carry=%b exp id=1 z=0 zero=1 ovf=0 carry=1",
                     rsp_id, rsp_z, rsp_zero, rsp_ovf, rsp_carry); end
        tick();
        $display("test_sub done: z=%h", rsp_z);
    endtask

    // Table of ops with hand-computed results {z, zero, ovf, carry}
    task automatic test_ops();
        logic [2:0] v_op  [7] = '{OP_NOT, OP_OR, OP_XOR, OP_EQ, OP_SLT, OP_ADD, OP_SUB};
        logic [3:0] v_x   [7] = '{4'h5, 4'h5, 4'hF, 4'h3, 4'h1, 4'hF, 4'h8};
        logic [3:0] v_y   [7] = '{4'h0, 4'hA, 4'h5, 4'h3, 4'h8, 4'h1, 4'h1};
        logic [6:0] v_exp [7] = '{{4'hA, 3'b000}, {4'hF, 3'b000}, {4'hA, 3'b000}, {4'h1, 3'b000},
                                  {4'h0, 3'b000}, {4'h0, 3'b101}, {4'h7, 3'b011}};
        bit got;
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_op(i[0], v_op[i], v_x[i], v_y[i], got);
            checks++;
            if (!got || {rsp_z, rsp_zero, rsp_ovf, rsp_carry} !== v_exp[i] || rsp_id !== i[0]) begin
                errors++;
                $display("FAIL ops_%0d got rsp=%b id=%b zfoc=%b exp id=%b zfoc=%b", i, got, rsp_id,
                         {rsp_z, rsp_zero, rsp_ovf, rsp_carry}, i[0], v_exp[i]);
            end
            $display("op %b x=%h y=%h -> z=%h flags=%b%b%b", v_op[i], v_x[i], v_y[i], rsp_z, rsp_zero, rsp_ovf, rsp_carry);
            tick();
        end
    endtask

    // Both requesters valid continuously: grants must alternate 0,1,0,1
    task automatic test_fairness();
        int n = 0;
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_AND; req0_x = 4'hF; req0_y = 4'h5;
        req1_valid = 1'b1; req1_op = OP_AND; req1_x = 4'hA; req1_y = 4'hC;
        #1;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL fair_dual_ready got 11 exp not both"); end
            if (rsp_valid) begin
                checks++;
                if (rsp_id !== n[0] || rsp_z !== (n[0] ? 4'h8 : 4'h5)) begin
                    errors++;
                    $display("FAIL fair_grant_%0d got id=%b z=%h exp id=%b z=%h", n, rsp_id, rsp_z, n[0], (n[0] ? 4'h8 : 4'h5));
                end
                $display("fair rsp %0d: id=%b z=%h", n, rsp_id, rsp_z);
                n++;
            end
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL fair_count got %0d exp 4", n); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();
    endtask

    // Held response under backpressure, SLT 8<1 signed
    task automatic test_backpressure();
        bit got;
        rsp_ready = 1'b0;
        send_op(1'b0, OP_SLT, 4'h8, 4'h1, got);
        checks++; if (!got) begin errors++; $display("FAIL bp_timeout got no rsp exp rsp_valid"); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_z !== 4'h1 || busy !== 1'b1 || req0_ready || req1_ready ||
                {rsp_zero, rsp_ovf, rsp_carry} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b z=%h busy=%b rdy=%b%b exp valid=1 z=1 busy=1 rdy=00", i,
                         rsp_valid, rsp_z, busy, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready || req1_ready) begin errors++; $display("FAIL bp_same_cycle_ready got %b%b exp 00", req0_ready, req1_ready); end
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_z !== 4'h1) begin errors++;
            $display("FAIL bp_release got busy=%b valid=%b z=%h exp busy=0 valid=0 z=1", busy, rsp_valid, rsp_z); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("test_backpressure done: z=%h", rsp_z);
        tick();
    endtask

    // Reset while in EXEC drops the op and restores req0 priority
    task automatic test_reset_in_exec();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 4'd1; req0_y = 4'd1;
        tick();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_exec_pre got busy=%b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rst_exec_drop got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
            $display("FAIL rst_exec_priority got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("test_reset_in_exec done");
        tick();
    endtask

    // Grant counters with STAT_W=2: saturate at 3
    task automatic test_stats();
        bit got;
        logic [STAT_W-1:0] exp0, exp1;
`ifdef ALU_ARB_STATS_EN
        exp0 = 2'd3; exp1 = 2'd1;
`else
        exp0 = 2'd0; exp1 = 2'd0;
`endif
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_op(1'b0, OP_XOR, 4'(i), 4'h3, got);
            checks++; if (!got || rsp_z !== (4'(i) ^ 4'h3)) begin errors++;
                $display("FAIL stats_op_%0d got rsp=%b z=%h exp z=%h", i, got, rsp_z, 4'(i) ^ 4'h3); end
            tick();
        end
        checks++; if (stat0_cnt !== exp0 || stat1_cnt !== 2'd0) begin errors++;
            $display("FAIL stats_sat got s0=%0d s1=%0d exp s0=%0d s1=0", stat0_cnt, stat1_cnt, exp0); end
        send_op(1'b1, OP_OR, 4'h1, 4'h2, got);
        tick();
        checks++; if (stat0_cnt !== exp0 || stat1_cnt !== exp1) begin errors++;
            $display("FAIL stats_req1 got s0=%0d s1=%0d exp s0=%0d s1=%0d", stat0_cnt, stat1_cnt, exp0, exp1); end
        $display("test_stats done: s0=%0d s1=%0d", stat0_cnt, stat1_cnt);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_x = 4'd0; req0_y = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_x = 4'd0; req1_y = 4'd0;
        test_reset();
        test_add_latency();
        test_sub();
        test_ops();
        test_fairness();
        test_backpressure();
        test_reset_in_exec();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
